// File: rtl/thread_scheduler_pkg.sv
// Shared types for the multithreaded frontend thread scheduler.
package thread_scheduler_pkg;

  typedef enum logic [1:0] {
    HALTED  = 2'd0,
    READY   = 2'd1,
    WAITING = 2'd2
  } thread_status_t;

  typedef enum logic [2:0] {
    IDLE,
    RESTORE,
    RUN,
    SAVE,
    SELECT
  } sched_state_e;

endpackage

// File: rtl/rr_thread_picker.sv
// Rotate-priority find-first: lowest id at or after ptr_i+1 (mod NUM) with its mask bit set.
module rr_thread_picker #(
  parameter int unsigned NUM  = 4,
  parameter int unsigned ID_W = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic [NUM-1:0]  mask_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [ID_W-1:0] id_o,
  output logic            found_o
);

  int off;
  int best;

  // Distance of candidate j from ptr_i+1; the smallest distance among set bits wins.
  always_comb begin
    id_o    = '0;
    found_o = 1'b0;
    off     = 0;
    best    = int'(NUM);
    for (int j = 0; j < int'(NUM); j++) begin
      off = (j + int'(NUM) - 1 - int'(ptr_i)) % int'(NUM);
      if (mask_i[j] && off < best) begin
        best    = off;
        id_o    = ID_W'(j);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Round-robin fine-grained thread scheduler: owns fetch, saves/restores per-thread PCs.
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter int unsigned NUM_THREADS    = 4,
  parameter int unsigned VLEN           = 39,
  parameter int unsigned QUANTUM_CYCLES = 64,
  parameter int unsigned TID_W          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  thread_status_t [NUM_THREADS-1:0] thread_status_i,
  input  logic                             switch_req_i,
  input  logic                             block_i,
  input  logic                             yield_i,
  input  logic [VLEN-1:0]                  fetch_pc_i,
  output logic                             flush_o,
  output logic                             ctx_pc_write_o,
  output logic [TID_W-1:0]                 ctx_pc_write_id_o,
  output logic [VLEN-1:0]                  ctx_pc_write_value_o,
  output logic [TID_W-1:0]                 ctx_pc_read_id_o,
  input  logic [VLEN-1:0]                  ctx_pc_value_i,
  output logic                             status_update_o,
  output logic [TID_W-1:0]                 status_update_id_o,
  output thread_status_t                   status_value_o,
  output logic                             restart_valid_o,
  output logic [VLEN-1:0]                  restart_pc_o,
  input  logic                             restart_ready_i,
  output logic [TID_W-1:0]                 active_thread_o,
  output logic                             active_valid_o
);

  localparam int unsigned CNT_W = $clog2(QUANTUM_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM_CYCLES - 1);

  sched_state_e     state_q, state_d;
  logic [TID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TID_W-1:0] next_q, next_d;
  logic [TID_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             block_q, block_d;

  logic [NUM_THREADS-1:0] ready_mask, active_oh, pick_mask;
  logic [TID_W-1:0]       pick_id;
  logic                   pick_found, others_ready, active_ready, quantum_up;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_ready
    assign ready_mask[t] = (thread_status_i[t] == READY);
  end

  assign active_oh    = NUM_THREADS'(1) << active_q;
  assign others_ready = |(ready_mask & ~active_oh);
  assign active_ready = |(ready_mask & active_oh);
  assign quantum_up   = (cnt_q == CNT_LAST);
  // A thread blocked on the way out must not win the very next selection.
  assign pick_mask    = (state_q == SELECT && block_q) ? (ready_mask & ~active_oh) : ready_mask;

  rr_thread_picker #(
    .NUM  (NUM_THREADS),
    .ID_W (TID_W)
  ) u_picker (
    .mask_i  (pick_mask),
    .ptr_i   (rr_ptr_q),
    .id_o    (pick_id),
    .found_o (pick_found)
  );

  always_comb begin
    state_d              = state_q;
    rr_ptr_d             = rr_ptr_q;
    next_d               = next_q;
    active_d             = active_q;
    cnt_d                = cnt_q;
    block_d              = block_q;
    flush_o              = 1'b0;
    ctx_pc_write_o       = 1'b0;
    ctx_pc_write_id_o    = '0;
    ctx_pc_write_value_o = '0;
    ctx_pc_read_id_o     = '0;
    status_update_o      = 1'b0;
    status_update_id_o   = '0;
    status_value_o       = HALTED;
    restart_valid_o      = 1'b0;
    restart_pc_o         = '0;
    active_valid_o       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          next_d  = pick_id;
          state_d = RESTORE;
        end
      end
      RESTORE: begin
        ctx_pc_read_id_o = next_q;
        restart_valid_o  = 1'b1;
        restart_pc_o     = ctx_pc_value_i;
        if (restart_ready_i) begin
          active_d = next_q;
          rr_ptr_d = next_q;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        active_valid_o = 1'b1;
        // Quantum expiry alone never evicts the only runnable thread; the counter wraps.
        if (switch_req_i || yield_i || !active_ready || (quantum_up && others_ready)) begin
          block_d = switch_req_i & block_i;
          state_d = SAVE;
        end else begin
          cnt_d = quantum_up ? '0 : cnt_q + 1'b1;
        end
      end
      SAVE: begin
        flush_o              = 1'b1;
        ctx_pc_write_o       = 1'b1;
        ctx_pc_write_id_o    = active_q;
        ctx_pc_write_value_o = fetch_pc_i;
        if (block_q) begin
          status_update_o    = 1'b1;
          status_update_id_o = active_q;
          status_value_o     = WAITING;
        end
        state_d = SELECT;
      end
      SELECT: begin
        if (pick_found) begin
          next_d  = pick_id;
          state_d = RESTORE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= TID_W'(NUM_THREADS - 1);
      next_q   <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      block_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      next_q   <= next_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      block_q  <= block_d;
    end
  end

  assign active_thread_o = active_q;

endmodule
